// File: rtl/ctrl_axil_master.sv
// Command/response front end driving a single-outstanding AXI-Lite master port.
// Optional response-wait timeout with late-response draining: define CTRL_AXIL_TIMEOUT_EN.
module ctrl_axil_master #(
    parameter int BW_AXI         = 32,
    parameter int BWB_AXI        = BW_AXI / 8,
    parameter int AXI_ADDR       = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk_control,
    input  logic                clk_control_rst_low,

    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [AXI_ADDR-1:0] cmd_addr,
    input  logic [BW_AXI-1:0]   cmd_wdata,
    input  logic [BWB_AXI-1:0]  cmd_wstrb,

    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [BW_AXI-1:0]   rsp_rdata,
    output logic [1:0]          rsp_resp,
    output logic                rsp_timeout,

    output logic [AXI_ADDR-1:0] control_M_AXI_AWADDR,
    output logic                control_M_AXI_AWVALID,
    input  logic                control_M_AXI_AWREADY,
    output logic [BW_AXI-1:0]   control_M_AXI_WDATA,
    output logic [BWB_AXI-1:0]  control_M_AXI_WSTRB,
    output logic                control_M_AXI_WVALID,
    input  logic                control_M_AXI_WREADY,
    input  logic [1:0]          control_M_AXI_BRESP,
    input  logic                control_M_AXI_BVALID,
    output logic                control_M_AXI_BREADY,
    output logic [AXI_ADDR-1:0] control_M_AXI_ARADDR,
    output logic                control_M_AXI_ARVALID,
    input  logic                control_M_AXI_ARREADY,
    input  logic [BW_AXI-1:0]   control_M_AXI_RDATA,
    input  logic [1:0]          control_M_AXI_RRESP,
    input  logic                control_M_AXI_RVALID,
    output logic                control_M_AXI_RREADY
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR_REQ = 3'd1,
        WAIT_B = 3'd2,
        RD_REQ = 3'd3,
        WAIT_R = 3'd4,
        RESP   = 3'd5
    } state_t;

    state_t              state_r, state_s;
    logic                awvalid_r, awvalid_s;
    logic                wvalid_r, wvalid_s;
    logic                arvalid_r, arvalid_s;
    logic                bready_r, bready_s;
    logic                rready_r, rready_s;
    logic                cmd_ready_r, cmd_ready_s;
    logic                rsp_valid_r, rsp_valid_s;
    logic                rsp_timeout_r, rsp_timeout_s;
    logic [BW_AXI-1:0]   rsp_rdata_r, rsp_rdata_s;
    logic [1:0]          rsp_resp_r, rsp_resp_s;
    logic [AXI_ADDR-1:0] addr_r;
    logic [BW_AXI-1:0]   wdata_r;
    logic [BWB_AXI-1:0]  wstrb_r;

    logic accept_s, b_hs_s, r_hs_s, aw_done_s, w_done_s;
    logic to_hit_s, drain_pend, drain_pend_s;

    assign accept_s  = cmd_valid && cmd_ready_r;
    assign b_hs_s    = control_M_AXI_BVALID && bready_r;
    assign r_hs_s    = control_M_AXI_RVALID && rready_r;
    assign aw_done_s = !awvalid_r || control_M_AXI_AWREADY;
    assign w_done_s  = !wvalid_r || control_M_AXI_WREADY;

`ifdef CTRL_AXIL_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] to_cnt_r;
    logic          waiting_s;

    assign waiting_s = ((state_r == WAIT_B) && !b_hs_s) || ((state_r == WAIT_R) && !r_hs_s);
    assign to_hit_s  = waiting_s && (to_cnt_r == TO_LAST);

    // Drain flag: set on timeout, cleared once the late response is swallowed in IDLE
    always_comb begin
        if (to_hit_s) begin
            drain_pend_s = 1'b1;
        end else if ((state_r == IDLE) && (b_hs_s || r_hs_s)) begin
            drain_pend_s = 1'b0;
        end else begin
            drain_pend_s = drain_pend;
        end
    end

    // Wait counter runs only while a response is outstanding; zero whenever outside WAIT states
    always_ff @(posedge clk_control or negedge clk_control_rst_low) begin
        if (!clk_control_rst_low) begin
            to_cnt_r   <= '0;
            drain_pend <= 1'b0;
        end else begin
            drain_pend <= drain_pend_s;
            if (waiting_s && !to_hit_s) begin
                to_cnt_r <= to_cnt_r + CW'(1);
            end else begin
                to_cnt_r <= '0;
            end
        end
    end
`else
    assign to_hit_s     = 1'b0;
    assign drain_pend   = 1'b0;
    assign drain_pend_s = 1'b0;
`endif

    // Next-state and next-output logic; every output register is loaded from these values
    always_comb begin
        state_s       = state_r;
        awvalid_s     = awvalid_r;
        wvalid_s      = wvalid_r;
        arvalid_s     = arvalid_r;
        rsp_rdata_s   = rsp_rdata_r;
        rsp_resp_s    = rsp_resp_r;
        rsp_timeout_s = rsp_timeout_r;
        case (state_r)
            IDLE: begin
                if (accept_s && cmd_write) begin
                    state_s   = WR_REQ;
                    awvalid_s = 1'b1;
                    wvalid_s  = 1'b1;
                end else if (accept_s) begin
                    state_s   = RD_REQ;
                    arvalid_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            WR_REQ: begin
                if (awvalid_r && control_M_AXI_AWREADY) begin
                    awvalid_s = 1'b0;
                end else begin
                    awvalid_s = awvalid_r;
                end
                if (wvalid_r && control_M_AXI_WREADY) begin
                    wvalid_s = 1'b0;
                end else begin
                    wvalid_s = wvalid_r;
                end
                if (aw_done_s && w_done_s) begin
                    state_s = WAIT_B;
                end else begin
                    state_s = WR_REQ;
                end
            end
            RD_REQ: begin
                if (control_M_AXI_ARREADY) begin
                    arvalid_s = 1'b0;
                    state_s   = WAIT_R;
                end else begin
                    state_s = RD_REQ;
                end
            end
            WAIT_B: begin
                if (b_hs_s) begin
                    state_s       = RESP;
                    rsp_resp_s    = control_M_AXI_BRESP;
                    rsp_rdata_s   = '0;
                    rsp_timeout_s = 1'b0;
                end else if (to_hit_s) begin
                    state_s       = RESP;
                    rsp_resp_s    = 2'b10;
                    rsp_rdata_s   = '0;
                    rsp_timeout_s = 1'b1;
                end else begin
                    state_s = WAIT_B;
                end
            end
            WAIT_R: begin
                if (r_hs_s) begin
                    state_s       = RESP;
                    rsp_resp_s    = control_M_AXI_RRESP;
                    rsp_rdata_s   = control_M_AXI_RDATA;
                    rsp_timeout_s = 1'b0;
                end else if (to_hit_s) begin
                    state_s       = RESP;
                    rsp_resp_s    = 2'b10;
                    rsp_rdata_s   = '0;
                    rsp_timeout_s = 1'b1;
                end else begin
                    state_s = WAIT_R;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s   = IDLE;
                awvalid_s = 1'b0;
                wvalid_s  = 1'b0;
                arvalid_s = 1'b0;
            end
        endcase

        cmd_ready_s = (state_s == IDLE) && !drain_pend_s;
        rsp_valid_s = (state_s == RESP);
        bready_s    = (state_s == WAIT_B) || ((state_s == IDLE) && drain_pend_s);
        rready_s    = (state_s == WAIT_R) || ((state_s == IDLE) && drain_pend_s);
    end

    // State and registered handshake/response outputs
    always_ff @(posedge clk_control or negedge clk_control_rst_low) begin
        if (!clk_control_rst_low) begin
            state_r       <= IDLE;
            awvalid_r     <= 1'b0;
            wvalid_r      <= 1'b0;
            arvalid_r     <= 1'b0;
            bready_r      <= 1'b0;
            rready_r      <= 1'b0;
            cmd_ready_r   <= 1'b0;
            rsp_valid_r   <= 1'b0;
            rsp_timeout_r <= 1'b0;
            rsp_rdata_r   <= '0;
            rsp_resp_r    <= 2'b00;
        end else begin
            state_r       <= state_s;
            awvalid_r     <= awvalid_s;
            wvalid_r      <= wvalid_s;
            arvalid_r     <= arvalid_s;
            bready_r      <= bready_s;
            rready_r      <= rready_s;
            cmd_ready_r   <= cmd_ready_s;
            rsp_valid_r   <= rsp_valid_s;
            rsp_timeout_r <= rsp_timeout_s;
            rsp_rdata_r   <= rsp_rdata_s;
            rsp_resp_r    <= rsp_resp_s;
        end
    end

    // Command payload is captured once at accept and held for the whole transaction
    always_ff @(posedge clk_control or negedge clk_control_rst_low) begin
        if (!clk_control_rst_low) begin
            addr_r  <= '0;
            wdata_r <= '0;
            wstrb_r <= '0;
        end else if (accept_s) begin
            addr_r  <= cmd_addr;
            wdata_r <= cmd_wdata;
            wstrb_r <= cmd_wstrb;
        end else begin
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
            wstrb_r <= wstrb_r;
        end
    end

    assign cmd_ready             = cmd_ready_r;
    assign rsp_valid             = rsp_valid_r;
    assign rsp_rdata             = rsp_rdata_r;
    assign rsp_resp              = rsp_resp_r;
    assign rsp_timeout           = rsp_timeout_r;
    assign control_M_AXI_AWADDR  = addr_r;
    assign control_M_AXI_AWVALID = awvalid_r;
    assign control_M_AXI_WDATA   = wdata_r;
    assign control_M_AXI_WSTRB   = wstrb_r;
    assign control_M_AXI_WVALID  = wvalid_r;
    assign control_M_AXI_BREADY  = bready_r;
    assign control_M_AXI_ARADDR  = addr_r;
    assign control_M_AXI_ARVALID = arvalid_r;
    assign control_M_AXI_RREADY  = rready_r;

endmodule

// File: tb/tb_ctrl_axil_master.sv
// Directed bench for ctrl_axil_master with a small behavioural AXI-Lite slave.
// The timeout scenario is exercised only when CTRL_AXIL_TIMEOUT_EN is defined.
module tb_ctrl_axil_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [7:0]  awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int checks = 0;
    int errors = 0;

    int   r_delay;
    logic r_block;
    logic aw_got, w_got, r_pend;
    int   r_cnt;

    ctrl_axil_master #(
        .BW_AXI(32), .BWB_AXI(4), .AXI_ADDR(8), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_control(clk), .clk_control_rst_low(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .control_M_AXI_AWADDR(awaddr), .control_M_AXI_AWVALID(awvalid), .control_M_AXI_AWREADY(awready),
        .control_M_AXI_WDATA(wdata), .control_M_AXI_WSTRB(wstrb), .control_M_AXI_WVALID(wvalid),
        .control_M_AXI_WREADY(wready), .control_M_AXI_BRESP(bresp), .control_M_AXI_BVALID(bvalid),
        .control_M_AXI_BREADY(bready), .control_M_AXI_ARADDR(araddr), .control_M_AXI_ARVALID(arvalid),
        .control_M_AXI_ARREADY(arready), .control_M_AXI_RDATA(rdata), .control_M_AXI_RRESP(rresp),
        .control_M_AXI_RVALID(rvalid), .control_M_AXI_RREADY(rready)
    );

    always #5 clk = ~clk;

    // Slave: B follows completion of both AW and W; R follows AR after r_delay cycles unless blocked
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_got <= 1'b0; w_got <= 1'b0; bvalid <= 1'b0;
            rvalid <= 1'b0; r_pend <= 1'b0; r_cnt <= 0;
        end else begin
            if (bvalid && bready) begin
                bvalid <= 1'b0;
            end else if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready))) begin
                bvalid <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
            end else begin
                if (awvalid && awready) aw_got <= 1'b1;
                if (wvalid && wready) w_got <= 1'b1;
            end
            if (rvalid && rready) rvalid <= 1'b0;
            if (arvalid && arready) begin
                if (r_delay == 0 && !r_block) begin
                    rvalid <= 1'b1;
                end else begin
                    r_pend <= 1'b1;
                    r_cnt  <= (r_delay > 0) ? r_delay - 1 : 0;
                end
            end else if (r_pend && !r_block) begin
                if (r_cnt == 0) begin
                    rvalid <= 1'b1; r_pend <= 1'b0;
                end else begin
                    r_cnt <= r_cnt - 1;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00;
        cmd_wdata = 32'h0; cmd_wstrb = 4'h0; rsp_ready = 1'b1;
        awready = 1'b1; wready = 1'b1; arready = 1'b1;
        bresp = 2'b00; rresp = 2'b00; rdata = 32'h0; r_delay = 0; r_block = 1'b0;
        #2;
        checks++;
        if ({cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready, rsp_timeout} !== 8'h00)
            begin errors++; $display("FAIL reset_ctrl: got %b expected 00000000",
                {cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready, rsp_timeout}); end
        checks++;
        if (rsp_rdata !== 32'h0 || rsp_resp !== 2'b00)
            begin errors++; $display("FAIL reset_rsp: got %h/%b expected 0/00", rsp_rdata, rsp_resp); end
        #10 rst_n = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL cmd_ready_before_edge: got %b expected 0", cmd_ready); end
        tick();
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL cmd_ready_after_reset: got %b expected 1", cmd_ready); end
    endtask

    task automatic test_read_zero_wait;
        rdata = 32'hA5A5_5A5A; rresp = 2'b10;
        issue(1'b0, 8'h04, 32'h0, 4'h0);
        checks++;
        if (arvalid !== 1'b1 || araddr !== 8'h04 || awvalid !== 1'b0)
            begin errors++; $display("FAIL rd0_ar: got arvalid=%b araddr=%h awvalid=%b expected 1/04/0", arvalid, araddr, awvalid); end
        tick();
        checks++;
        if (rready !== 1'b1 || rsp_valid !== 1'b0)
            begin errors++; $display("FAIL rd0_wait: got rready=%b rsp_valid=%b expected 1/0", rready, rsp_valid); end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5A5_5A5A || rsp_resp !== 2'b10 || rsp_timeout !== 1'b0)
            begin errors++; $display("FAIL rd0_rsp: got %b/%h/%b/%b expected 1/a5a55a5a/10/0", rsp_valid, rsp_rdata, rsp_resp, rsp_timeout); end
        tick();
        rresp = 2'b00;
    endtask

    task automatic test_write_zero_wait;
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL wr0_ready: got %b expected 1", cmd_ready); end
        issue(1'b1, 8'h08, 32'hDEAD_BEEF, 4'hF);
        checks++;
        if (awvalid !== 1'b1 || wvalid !== 1'b1 || cmd_ready !== 1'b0)
            begin errors++; $display("FAIL wr0_valids: got aw=%b w=%b cmd_ready=%b expected 1/1/0", awvalid, wvalid, cmd_ready); end
        checks++;
        if (awaddr !== 8'h08 || wdata !== 32'hDEAD_BEEF || wstrb !== 4'hF)
            begin errors++; $display("FAIL wr0_payload: got %h/%h/%h expected 08/deadbeef/f", awaddr, wdata, wstrb); end
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || bready !== 1'b1 || awvalid !== 1'b0)
            begin errors++; $display("FAIL wr0_waitb: got rsp_valid=%b bready=%b aw=%b expected 0/1/0", rsp_valid, bready, awvalid); end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_resp !== 2'b00 || rsp_rdata !== 32'h0)
            begin errors++; $display("FAIL wr0_rsp: got %b/%b/%h expected 1/00/0", rsp_valid, rsp_resp, rsp_rdata); end
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
            begin errors++; $display("FAIL wr0_idle: got rsp_valid=%b cmd_ready=%b expected 0/1", rsp_valid, cmd_ready); end
    endtask

    task automatic test_read_delayed;
        int n;
        arready = 1'b0; r_delay = 5; rdata = 32'h1234_5678; rresp = 2'b00;
        issue(1'b0, 8'h0C, 32'h0, 4'h0);
        for (int k = 1; k <= 3; k++) begin
            checks++;
            if (arvalid !== 1'b1 || araddr !== 8'h0C)
                begin errors++; $display("FAIL rd_ar_hold%0d: got %b/%h expected 1/0c", k, arvalid, araddr); end
            if (k == 3) arready = 1'b1;
            tick();
        end
        checks++;
        if (arvalid !== 1'b0) begin errors++; $display("FAIL rd_ar_drop: got %b expected 0", arvalid); end
        n = 4;
        while (rsp_valid !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 10) begin errors++; $display("FAIL rd_latency: got cycle %0d expected 10", n); end
        checks++;
        if (rsp_rdata !== 32'h1234_5678 || rsp_resp !== 2'b00)
            begin errors++; $display("FAIL rd_data: got %h/%b expected 12345678/00", rsp_rdata, rsp_resp); end
        tick();
        r_delay = 0;
    endtask

    task automatic test_write_split;
        awready = 1'b1; wready = 1'b0;
        issue(1'b1, 8'h14, 32'hCAFE_0001, 4'h3);
        checks++;
        if (awvalid !== 1'b1 || wvalid !== 1'b1)
            begin errors++; $display("FAIL split_c1: got aw=%b w=%b expected 1/1", awvalid, wvalid); end
        tick();
        awready = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            checks++;
            if (awvalid !== 1'b0 || wvalid !== 1'b1 || bready !== 1'b0 || wdata !== 32'hCAFE_0001)
                begin errors++; $display("FAIL split_c%0d: got aw=%b w=%b bready=%b wdata=%h expected 0/1/0/cafe0001", k, awvalid, wvalid, bready, wdata); end
            if (k == 4) wready = 1'b1;
            tick();
        end
        checks++;
        if (wvalid !== 1'b0 || bready !== 1'b1)
            begin errors++; $display("FAIL split_c5: got w=%b bready=%b expected 0/1", wvalid, bready); end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_resp !== 2'b00)
            begin errors++; $display("FAIL split_rsp: got %b/%b expected 1/00", rsp_valid, rsp_resp); end
        awready = 1'b1;
        tick();
    endtask

    task automatic test_write_err_hold;
        bresp = 2'b11; rsp_ready = 1'b0;
        issue(1'b1, 8'h18, 32'h0000_00FF, 4'h1);
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_resp !== 2'b11 || rsp_rdata !== 32'h0 || cmd_ready !== 1'b0)
                begin errors++; $display("FAIL err_hold%0d: got %b/%b/%h/%b expected 1/11/0/0", k, rsp_valid, rsp_resp, rsp_rdata, cmd_ready); end
            if (k == 2) rsp_ready = 1'b1;
            tick();
        end
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
            begin errors++; $display("FAIL err_release: got rsp_valid=%b cmd_ready=%b expected 0/1", rsp_valid, cmd_ready); end
        bresp = 2'b00;
    endtask

    task automatic test_back_to_back;
        int acc_t[4];
        int n_acc;
        int n_rsp;
        n_acc = 0; n_rsp = 0;
        cmd_valid = 1'b1; cmd_addr = 8'h20; cmd_wdata = 32'h5555_AAAA; cmd_wstrb = 4'hF;
        for (int i = 0; i <= 12; i++) begin
            if (rsp_valid === 1'b1) n_rsp++;
            if (cmd_ready === 1'b1 && n_acc < 4) begin
                acc_t[n_acc] = i;
                cmd_write = n_acc[0] ? 1'b0 : 1'b1;
                n_acc++;
            end
            if (i == 12) cmd_valid = 1'b0;
            else tick();
        end
        checks++;
        if (n_acc !== 4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", n_acc); end
        else begin
            checks++;
            if (acc_t[1] - acc_t[0] !== 4 || acc_t[2] - acc_t[1] !== 4 || acc_t[3] - acc_t[2] !== 4)
                begin errors++; $display("FAIL b2b_period: got %0d,%0d,%0d,%0d expected 0,4,8,12", acc_t[0], acc_t[1], acc_t[2], acc_t[3]); end
        end
        checks++;
        if (n_rsp !== 3) begin errors++; $display("FAIL b2b_rsps: got %0d expected 3", n_rsp); end
    endtask

    task automatic test_reset_mid;
        logic seen;
        awready = 1'b0; wready = 1'b0;
        issue(1'b1, 8'h30, 32'h1111_2222, 4'hF);
        checks++;
        if (awvalid !== 1'b1) begin errors++; $display("FAIL mid_awvalid: got %b expected 1", awvalid); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready, rsp_timeout} !== 8'h00 || rsp_resp !== 2'b00)
            begin errors++; $display("FAIL mid_async: got %b/%b expected 00000000/00",
                {cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready, rsp_timeout}, rsp_resp); end
        #3 rst_n = 1'b1;
        awready = 1'b1; wready = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_early: got %b expected 0", cmd_ready); end
        tick();
        seen = 1'b0;
        checks++;
        if (cmd_ready !== 1'b1 || awvalid !== 1'b0)
            begin errors++; $display("FAIL mid_ready: got cmd_ready=%b aw=%b expected 1/0", cmd_ready, awvalid); end
        for (int k = 0; k < 4; k++) begin
            if (rsp_valid === 1'b1) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL mid_no_rsp: got %b expected 0", seen); end
        issue(1'b1, 8'h10, 32'h0BAD_F00D, 4'hF);
        checks++;
        if (awvalid !== 1'b1 || awaddr !== 8'h10 || wdata !== 32'h0BAD_F00D)
            begin errors++; $display("FAIL mid_new_wr: got %b/%h/%h expected 1/10/0badf00d", awvalid, awaddr, wdata); end
        tick();
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_resp !== 2'b00)
            begin errors++; $display("FAIL mid_new_rsp: got %b/%b expected 1/00", rsp_valid, rsp_resp); end
        tick();
    endtask

`ifdef CTRL_AXIL_TIMEOUT_EN
    task automatic test_timeout;
        int n;
        logic seen;
        r_block = 1'b1; rdata = 32'h7777_8888;
        issue(1'b0, 8'h24, 32'h0, 4'h0);
        tick();
        repeat (15) tick();
        checks++;
        if (rready !== 1'b1 || rsp_valid !== 1'b0)
            begin errors++; $display("FAIL to_wait: got rready=%b rsp_valid=%b expected 1/0", rready, rsp_valid); end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b1 || rsp_resp !== 2'b10 || rsp_rdata !== 32'h0)
            begin errors++; $display("FAIL to_rsp: got %b/%b/%b/%h expected 1/1/10/0", rsp_valid, rsp_timeout, rsp_resp, rsp_rdata); end
        tick();
        repeat (3) tick();
        checks++;
        if (cmd_ready !== 1'b0 || rready !== 1'b1)
            begin errors++; $display("FAIL to_drain: got cmd_ready=%b rready=%b expected 0/1", cmd_ready, rready); end
        r_block = 1'b0;
        n = 0; seen = 1'b0;
        while (cmd_ready !== 1'b1 && n < 10) begin
            tick();
            if (rsp_valid === 1'b1) seen = 1'b1;
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1 || seen !== 1'b0)
            begin errors++; $display("FAIL to_absorb: got cmd_ready=%b rsp_seen=%b expected 1/0", cmd_ready, seen); end
        issue(1'b0, 8'h28, 32'h0, 4'h0);
        tick();
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'h7777_8888)
            begin errors++; $display("FAIL to_recover: got %b/%b/%h expected 1/0/77778888", rsp_valid, rsp_timeout, rsp_rdata); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_read_zero_wait();
        test_write_zero_wait();
        test_read_delayed();
        test_write_split();
        test_write_err_hold();
        test_back_to_back();
        test_reset_mid();
`ifdef CTRL_AXIL_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
